// File: rtl/cu_cta_dispatch_if.sv
// ---------------------------------------------------------------------------
// cu_cta_dispatch_if
//   CTA descriptor channel from the CTA dispatcher to the warp scheduler.
//   One descriptor moves on every cycle where cta_valid && cta_ready.
//
//   cta_valid      descriptor valid (dispatcher -> scheduler)
//   cta_ready      scheduler accepts descriptor (scheduler -> dispatcher)
//   cta_ctaid_x/y/z  CTA index within the grid
//   cta_ntid_x/y/z   block dimensions latched at kernel start
//   cta_init_pc    kernel entry pc latched at kernel start
//   cta_last       descriptor is the final CTA of the kernel
//
//   master modport: dispatcher side; slave modport: scheduler side.
// ---------------------------------------------------------------------------
interface cu_cta_dispatch_if #(
  parameter int unsigned GW = 32
);
  logic          cta_valid;
  logic          cta_ready;
  logic [GW-1:0] cta_ctaid_x;
  logic [GW-1:0] cta_ctaid_y;
  logic [GW-1:0] cta_ctaid_z;
  logic [11:0]   cta_ntid_x;
  logic [11:0]   cta_ntid_y;
  logic [5:0]    cta_ntid_z;
  logic [31:0]   cta_init_pc;
  logic          cta_last;

  modport master (
    output cta_valid,
    input  cta_ready,
    output cta_ctaid_x, cta_ctaid_y, cta_ctaid_z,
    output cta_ntid_x, cta_ntid_y, cta_ntid_z,
    output cta_init_pc,
    output cta_last
  );

  modport slave (
    input  cta_valid,
    output cta_ready,
    input  cta_ctaid_x, cta_ctaid_y, cta_ctaid_z,
    input  cta_ntid_x, cta_ntid_y, cta_ntid_z,
    input  cta_init_pc,
    input  cta_last
  );
endinterface

// File: rtl/cu_cta_dispatch.sv
// ---------------------------------------------------------------------------
// cu_cta_dispatch
//   Takes the kernel-start command from the CU CSR block, latches the launch
//   configuration and walks the 3-D grid (x fastest, then y, then z), handing
//   one CTA descriptor per grid point to the warp scheduler.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     clear             synchronous soft clear (shared with the CSR block)
//     kernel_start_en   one-cycle CSR write strobe for the start command
//     kernel_start      command data bit; start only with kernel_start_en
//     cfg_nctaid_x/y/z  grid dimensions
//     cfg_ntid_x/y/z    block dimensions
//     cfg_init_pc       kernel entry pc
//     cta               descriptor channel (master side)
//     busy              kernel in progress
//     done              one-cycle pulse when the kernel finishes
//     zero_grid_err     one-cycle pulse: start accepted with a zero dimension
//     start_drop        one-cycle pulse: start ignored because busy
//     issued_cnt        CTAs accepted for the current or last kernel
// ---------------------------------------------------------------------------
module cu_cta_dispatch #(
  parameter int unsigned GW   = 32,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            kernel_start_en,
  input  logic            kernel_start,
  input  logic [GW-1:0]   cfg_nctaid_x,
  input  logic [GW-1:0]   cfg_nctaid_y,
  input  logic [GW-1:0]   cfg_nctaid_z,
  input  logic [11:0]     cfg_ntid_x,
  input  logic [11:0]     cfg_ntid_y,
  input  logic [5:0]      cfg_ntid_z,
  input  logic [31:0]     cfg_init_pc,
  cu_cta_dispatch_if.master cta,
  output logic            busy,
  output logic            done,
  output logic            zero_grid_err,
  output logic            start_drop,
  output logic [CNTW-1:0] issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t          r_state;

  // Shadow copy of the launch configuration for the running kernel.
  logic [GW-1:0]   r_nx;
  logic [GW-1:0]   r_ny;
  logic [GW-1:0]   r_nz;
  logic [11:0]     r_ntid_x;
  logic [11:0]     r_ntid_y;
  logic [5:0]      r_ntid_z;
  logic [31:0]     r_init_pc;

  // Grid walk counters; they are the ctaid of the descriptor on offer.
  logic [GW-1:0]   r_cx;
  logic [GW-1:0]   r_cy;
  logic [GW-1:0]   r_cz;

  logic [CNTW-1:0] r_issued;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_zero_err;
  logic            r_start_drop;

  logic            w_start;
  logic            w_cfg_zero;
  logic            w_xfer;
  logic            w_x_end;
  logic            w_y_end;
  logic            w_z_end;
  logic            w_last;

  assign w_start    = kernel_start_en & kernel_start;
  assign w_cfg_zero = (cfg_nctaid_x == '0) | (cfg_nctaid_y == '0) |
                      (cfg_nctaid_z == '0);
  assign w_xfer     = r_valid & cta.cta_ready;

  // Compare against dim-1 rather than counting up to dim, so a dimension of
  // all-ones never needs a counter value beyond the representable range.
  assign w_x_end    = (r_cx == r_nx - GW'(1));
  assign w_y_end    = (r_cy == r_ny - GW'(1));
  assign w_z_end    = (r_cz == r_nz - GW'(1));
  assign w_last     = w_x_end & w_y_end & w_z_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_nx         <= '0;
      r_ny         <= '0;
      r_nz         <= '0;
      r_ntid_x     <= '0;
      r_ntid_y     <= '0;
      r_ntid_z     <= '0;
      r_init_pc    <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_cz         <= '0;
      r_issued     <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_zero_err   <= 1'b0;
      r_start_drop <= 1'b0;
    end else if (clear) begin
      // Soft clear wipes everything, including a start in the same cycle.
      r_state      <= S_IDLE;
      r_nx         <= '0;
      r_ny         <= '0;
      r_nz         <= '0;
      r_ntid_x     <= '0;
      r_ntid_y     <= '0;
      r_ntid_z     <= '0;
      r_init_pc    <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_cz         <= '0;
      r_issued     <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_zero_err   <= 1'b0;
      r_start_drop <= 1'b0;
    end else begin
      r_zero_err   <= 1'b0;
      r_start_drop <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_nx      <= cfg_nctaid_x;
            r_ny      <= cfg_nctaid_y;
            r_nz      <= cfg_nctaid_z;
            r_ntid_x  <= cfg_ntid_x;
            r_ntid_y  <= cfg_ntid_y;
            r_ntid_z  <= cfg_ntid_z;
            r_init_pc <= cfg_init_pc;
            r_cx      <= '0;
            r_cy      <= '0;
            r_cz      <= '0;
            r_issued  <= '0;
            r_busy    <= 1'b1;
            if (w_cfg_zero) begin
              // Empty grid: report and finish without issuing anything.
              r_state    <= S_FIN;
              r_done     <= 1'b1;
              r_zero_err <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_valid <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (w_start) begin
            r_start_drop <= 1'b1;
          end
          if (w_xfer) begin
            if (r_issued != '1) begin
              r_issued <= r_issued + CNTW'(1);
            end
            if (w_x_end) begin
              r_cx <= '0;
              if (w_y_end) begin
                r_cy <= '0;
                r_cz <= r_cz + GW'(1);
              end else begin
                r_cy <= r_cy + GW'(1);
              end
            end else begin
              r_cx <= r_cx + GW'(1);
            end
            if (w_last) begin
              r_state <= S_FIN;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        S_FIN: begin
          if (w_start) begin
            r_start_drop <= 1'b1;
          end
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cta.cta_valid   = r_valid;
  assign cta.cta_ctaid_x = r_cx;
  assign cta.cta_ctaid_y = r_cy;
  assign cta.cta_ctaid_z = r_cz;
  assign cta.cta_ntid_x  = r_ntid_x;
  assign cta.cta_ntid_y  = r_ntid_y;
  assign cta.cta_ntid_z  = r_ntid_z;
  assign cta.cta_init_pc = r_init_pc;
  assign cta.cta_last    = w_last;

  assign busy            = r_busy;
  assign done            = r_done;
  assign zero_grid_err   = r_zero_err;
  assign start_drop      = r_start_drop;
  assign issued_cnt      = r_issued;

endmodule

// File: tb/tb_cu_cta_dispatch.sv
// ---------------------------------------------------------------------------
// tb_cu_cta_dispatch
//   Directed bench for cu_cta_dispatch. A reference model expands each
//   accepted kernel into its full list of descriptors and tracks how far
//   the scheduler has consumed it; a negedge process compares every output
//   against that model each cycle, and directed scenarios pin the model
//   with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_cu_cta_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        kernel_start_en = 1'b0;
  logic        kernel_start = 1'b0;
  logic [31:0] cfg_nctaid_x = '0;
  logic [31:0] cfg_nctaid_y = '0;
  logic [31:0] cfg_nctaid_z = '0;
  logic [11:0] cfg_ntid_x = '0;
  logic [11:0] cfg_ntid_y = '0;
  logic [5:0]  cfg_ntid_z = '0;
  logic [31:0] cfg_init_pc = '0;
  logic        busy;
  logic        done;
  logic        zero_grid_err;
  logic        start_drop;
  logic [31:0] issued_cnt;

  logic        rnd_mode = 1'b0;
  logic        rnd_bit = 1'b0;
  logic        fix_ready = 1'b1;

  cu_cta_dispatch_if #(.GW(32)) cta_if ();

  cu_cta_dispatch #(.GW(32), .CNTW(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .kernel_start_en (kernel_start_en),
    .kernel_start    (kernel_start),
    .cfg_nctaid_x    (cfg_nctaid_x),
    .cfg_nctaid_y    (cfg_nctaid_y),
    .cfg_nctaid_z    (cfg_nctaid_z),
    .cfg_ntid_x      (cfg_ntid_x),
    .cfg_ntid_y      (cfg_ntid_y),
    .cfg_ntid_z      (cfg_ntid_z),
    .cfg_init_pc     (cfg_init_pc),
    .cta             (cta_if),
    .busy            (busy),
    .done            (done),
    .zero_grid_err   (zero_grid_err),
    .start_drop      (start_drop),
    .issued_cnt      (issued_cnt)
  );

  always #5 clk = ~clk;

  assign cta_if.cta_ready = rnd_mode ? rnd_bit : fix_ready;
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_mode: 0 idle, 1 offering descriptors, 2 finishing cycle
  int          m_mode = 0;
  int unsigned m_qx[$];
  int unsigned m_qy[$];
  int unsigned m_qz[$];
  int          m_idx = 0;
  logic [31:0] m_issued = '0;
  logic        m_zerr = 1'b0;
  logic        m_drop = 1'b0;
  logic [11:0] m_ntx = '0;
  logic [11:0] m_nty = '0;
  logic [5:0]  m_ntz = '0;
  logic [31:0] m_pc = '0;

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_issued = '0; m_zerr = 1'b0; m_drop = 1'b0;
    m_ntx = '0; m_nty = '0; m_ntz = '0; m_pc = '0;
    m_qx.delete(); m_qy.delete(); m_qz.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      model_reset();
    end else begin
      logic st;
      st = kernel_start_en && kernel_start;
      m_zerr = 1'b0;
      m_drop = 1'b0;
      if (m_mode == 0) begin
        if (st) begin
          m_ntx = cfg_ntid_x; m_nty = cfg_ntid_y; m_ntz = cfg_ntid_z;
          m_pc = cfg_init_pc; m_issued = '0; m_idx = 0;
          m_qx.delete(); m_qy.delete(); m_qz.delete();
          for (int unsigned z = 0; z < cfg_nctaid_z; z++)
            for (int unsigned y = 0; y < cfg_nctaid_y; y++)
              for (int unsigned x = 0; x < cfg_nctaid_x; x++) begin
                m_qx.push_back(x); m_qy.push_back(y); m_qz.push_back(z);
              end
          if (m_qx.size() == 0) begin
            m_mode = 2; m_zerr = 1'b1;
          end else begin
            m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (st) m_drop = 1'b1;
        if (cta_if.cta_ready) begin
          if (m_issued != 32'hFFFF_FFFF) m_issued = m_issued + 1;
          if (m_idx == m_qx.size() - 1) m_mode = 2;
          else m_idx++;
        end
      end else begin
        if (st) m_drop = 1'b1;
        m_mode = 0;
      end
    end
  end

  // ---------------- transfer log and event counters ----------------
  int unsigned lx[$];
  int unsigned ly[$];
  int unsigned lz[$];
  logic        llast[$];
  int          done_seen = 0;
  int          drop_seen = 0;
  int          zerr_seen = 0;

  always @(posedge clk) begin
    if (rst_n && !clear && cta_if.cta_valid && cta_if.cta_ready) begin
      lx.push_back(cta_if.cta_ctaid_x);
      ly.push_back(cta_if.cta_ctaid_y);
      lz.push_back(cta_if.cta_ctaid_z);
      llast.push_back(cta_if.cta_last);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", 64'(cta_if.cta_valid), 64'(m_mode == 1));
      check("busy", 64'(busy), 64'(m_mode != 0));
      check("done", 64'(done), 64'(m_mode == 2));
      check("zero_grid_err", 64'(zero_grid_err), 64'(m_zerr));
      check("start_drop", 64'(start_drop), 64'(m_drop));
      check("issued_cnt", 64'(issued_cnt), 64'(m_issued));
      if (m_mode == 1) begin
        check("ctaid_x", 64'(cta_if.cta_ctaid_x), 64'(m_qx[m_idx]));
        check("ctaid_y", 64'(cta_if.cta_ctaid_y), 64'(m_qy[m_idx]));
        check("ctaid_z", 64'(cta_if.cta_ctaid_z), 64'(m_qz[m_idx]));
        check("cta_last", 64'(cta_if.cta_last),
              64'(m_idx == m_qx.size() - 1));
        check("ntid_x", 64'(cta_if.cta_ntid_x), 64'(m_ntx));
        check("ntid_y", 64'(cta_if.cta_ntid_y), 64'(m_nty));
        check("ntid_z", 64'(cta_if.cta_ntid_z), 64'(m_ntz));
        check("init_pc", 64'(cta_if.cta_init_pc), 64'(m_pc));
      end
      if (done) done_seen++;
      if (start_drop) drop_seen++;
      if (zero_grid_err) zerr_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_kernel(input int unsigned nx, input int unsigned ny,
                              input int unsigned nz, input logic [11:0] tx,
                              input logic [11:0] ty, input logic [5:0] tz,
                              input logic [31:0] pc);
    cfg_nctaid_x = nx; cfg_nctaid_y = ny; cfg_nctaid_z = nz;
    cfg_ntid_x = tx; cfg_ntid_y = ty; cfg_ntid_z = tz; cfg_init_pc = pc;
    kernel_start_en = 1'b1; kernel_start = 1'b1;
    @(negedge clk);
    kernel_start_en = 1'b0; kernel_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic clear_log();
    lx.delete(); ly.delete(); lz.delete(); llast.delete();
    done_seen = 0; drop_seen = 0; zerr_seen = 0;
  endtask

  initial begin
    int unsigned ex[6];
    int unsigned ey[6];
    int unsigned ez[6];
    bit got2;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(cta_if.cta_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issued", 64'(issued_cnt), 64'd0);
    check("rst_ctaid_x", 64'(cta_if.cta_ctaid_x), 64'd0);
    check("rst_pc", 64'(cta_if.cta_init_pc), 64'd0);
    check("rst_last", 64'(cta_if.cta_last), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- 2x2x1, ready tied high ----
    clear_log();
    fix_ready = 1'b1;
    start_kernel(2, 2, 1, 12'd32, 12'd4, 6'd1, 32'h0000_1000);
    check("g221_valid_at_plus1", 64'(cta_if.cta_valid), 64'd1);
    wait_idle("g221");
    ex = '{0, 1, 0, 1, 0, 0}; ey = '{0, 0, 1, 1, 0, 0};
    check("g221_count", 64'(lx.size()), 64'd4);
    if (lx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("g221_x", 64'(lx[i]), 64'(ex[i]));
        check("g221_y", 64'(ly[i]), 64'(ey[i]));
        check("g221_z", 64'(lz[i]), 64'd0);
        check("g221_last", 64'(llast[i]), 64'(i == 3));
      end
    end
    check("g221_issued", 64'(issued_cnt), 64'd4);
    check("g221_done_once", 64'(done_seen), 64'd1);

    // ---- 3x1x2, random ready, cfg changes mid-kernel ----
    clear_log();
    rnd_mode = 1'b1;
    start_kernel(3, 1, 2, 12'd64, 12'd2, 6'd3, 32'hDEAD_0040);
    repeat (3) @(negedge clk);
    cfg_ntid_x = 12'd7; cfg_ntid_y = 12'd9; cfg_ntid_z = 6'd5;
    cfg_init_pc = 32'h1234_5678; cfg_nctaid_x = 5;
    wait_idle("g312");
    rnd_mode = 1'b0;
    ex = '{0, 1, 2, 0, 1, 2}; ez = '{0, 0, 0, 1, 1, 1};
    check("g312_count", 64'(lx.size()), 64'd6);
    if (lx.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("g312_x", 64'(lx[i]), 64'(ex[i]));
        check("g312_y", 64'(ly[i]), 64'd0);
        check("g312_z", 64'(lz[i]), 64'(ez[i]));
      end
    end
    check("g312_issued", 64'(issued_cnt), 64'd6);

    // ---- zero grid dimension ----
    clear_log();
    start_kernel(2, 0, 1, 12'd1, 12'd1, 6'd1, 32'h0000_0200);
    check("zero_err_pulse", 64'(zero_grid_err), 64'd1);
    check("zero_done_pulse", 64'(done), 64'd1);
    check("zero_no_valid", 64'(cta_if.cta_valid), 64'd0);
    @(negedge clk);
    check("zero_busy_1cyc", 64'(busy), 64'd0);
    check("zero_issued", 64'(issued_cnt), 64'd0);
    check("zero_no_xfer", 64'(lx.size()), 64'd0);

    // ---- second start during a 4x1x1 kernel ----
    clear_log();
    start_kernel(4, 1, 1, 12'd8, 12'd1, 6'd1, 32'h0000_0300);
    start_kernel(9, 9, 9, 12'd3, 12'd3, 6'd3, 32'h0000_0400);
    wait_idle("g411");
    check("g411_drop_once", 64'(drop_seen), 64'd1);
    check("g411_count", 64'(lx.size()), 64'd4);
    check("g411_issued", 64'(issued_cnt), 64'd4);
    // start strobe with data bit 0 is a no-op
    kernel_start_en = 1'b1; kernel_start = 1'b0;
    @(negedge clk);
    kernel_start_en = 1'b0;
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_valid", 64'(cta_if.cta_valid), 64'd0);
    check("noop_issued", 64'(issued_cnt), 64'd4);

    // ---- clear after 2 of 8 CTAs, with a start in the clear cycle ----
    clear_log();
    start_kernel(8, 1, 1, 12'd16, 12'd1, 6'd1, 32'h0000_0500);
    got2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (lx.size() >= 2) begin
        got2 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("clr_reach2", 64'(got2), 64'd1);
    clear = 1'b1; fix_ready = 1'b0;
    cfg_nctaid_x = 1; cfg_nctaid_y = 1; cfg_nctaid_z = 1;
    kernel_start_en = 1'b1; kernel_start = 1'b1;
    @(negedge clk);
    clear = 1'b0; kernel_start_en = 1'b0; kernel_start = 1'b0;
    fix_ready = 1'b1;
    check("clr_valid", 64'(cta_if.cta_valid), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_issued", 64'(issued_cnt), 64'd0);
    check("clr_ctaid_x", 64'(cta_if.cta_ctaid_x), 64'd0);
    @(negedge clk);
    check("clr_start_discarded", 64'(busy), 64'd0);
    check("clr_no_done", 64'(done_seen), 64'd0);
    clear_log();
    start_kernel(1, 1, 1, 12'd1, 12'd1, 6'd1, 32'h0000_0600);
    check("clr_111_last", 64'(cta_if.cta_last), 64'd1);
    wait_idle("clr_111");
    check("clr_111_count", 64'(lx.size()), 64'd1);
    if (lx.size() == 1) begin
      check("clr_111_xyz", 64'(lx[0] + ly[0] + lz[0]), 64'd0);
      check("clr_111_lastlog", 64'(llast[0]), 64'd1);
    end
    check("clr_111_done", 64'(done_seen), 64'd1);

    // ---- asynchronous reset mid-kernel ----
    clear_log();
    start_kernel(8, 1, 1, 12'd16, 12'd1, 6'd1, 32'h0000_0700);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(cta_if.cta_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_issued", 64'(issued_cnt), 64'd0);
    check("arst_ctaid_x", 64'(cta_if.cta_ctaid_x), 64'd0);
    check("arst_pc", 64'(cta_if.cta_init_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    start_kernel(1, 1, 1, 12'd2, 12'd2, 6'd2, 32'h0000_0800);
    wait_idle("arst_111");
    check("arst_111_count", 64'(lx.size()), 64'd1);
    check("arst_111_done", 64'(done_seen), 64'd1);
    check("arst_111_issued", 64'(issued_cnt), 64'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
